// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared codes, state encoding and sizing helpers for the hazard controller
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] PC_SEL_NORM = 2'd0;
    localparam logic [1:0] PC_SEL_EXC  = 2'd1;
    localparam logic [1:0] PC_SEL_EPC  = 2'd2;

    localparam int REG_W_DEF    = 5;
    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } flush_state_t;

    // Counter must hold the longer latency and never shrink below 4 bits.
    function automatic int md_cnt_width(input int mult_cyc, input int div_cyc);
        int m;
        int w;
        m = (mult_cyc > div_cyc) ? mult_cyc : div_cyc;
        w = $clog2(m + 1);
        return (w < 4) ? 4 : w;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - datapath <-> hazard controller signal bundle
interface pipe_hazard_ctrl_if #(
    parameter int REG_W = 5
);
    logic [REG_W-1:0] d_rs;
    logic [REG_W-1:0] d_rt;
    logic             d_rs_use;
    logic             d_rt_use;
    logic             d_branch;
    logic             d_md_use;
    logic             d_clear_req;
    logic [REG_W-1:0] e_wa;
    logic [REG_W-1:0] m_wa;
    logic             e_is_load;
    logic             m_is_load;
    logic             e_md_start;
    logic             e_md_div;
    logic             m_exc;
    logic             m_eret;
    logic             m_valid;
    logic             int_req;

    logic             f_en;
    logic             d_en;
    logic             m_en;
    logic             w_en;
    logic             d_flush;
    logic             e_reset;
    logic             flush;
    logic [1:0]       pc_sel;
    logic             md_busy;

    modport master (
        output d_rs, d_rt, d_rs_use, d_rt_use, d_branch, d_md_use, d_clear_req,
        output e_wa, m_wa, e_is_load, m_is_load, e_md_start, e_md_div,
        output m_exc, m_eret, m_valid, int_req,
        input  f_en, d_en, m_en, w_en, d_flush, e_reset, flush, pc_sel, md_busy
    );

    modport slave (
        input  d_rs, d_rt, d_rs_use, d_rt_use, d_branch, d_md_use, d_clear_req,
        input  e_wa, m_wa, e_is_load, m_is_load, e_md_start, e_md_div,
        input  m_exc, m_eret, m_valid, int_req,
        output f_en, d_en, m_en, w_en, d_flush, e_reset, flush, pc_sel, md_busy
    );

endinterface

// File: rtl/pipe_hazard_ctrl_md_busy_cnt.sv
// rtl/pipe_hazard_ctrl_md_busy_cnt.sv - mult/div latency counter; busy while nonzero
module md_busy_cnt #(
    parameter int CNT_W    = 4,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic i_start,
    input  logic i_div,
    output logic o_busy
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_cnt <= i_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline stall/bubble/flush control with mult/div tracking
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_W    = REG_W_DEF,
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic               clk,
    input  logic               reset,
    pipe_hazard_ctrl_if.slave  hz
);

    localparam int CNT_W = md_cnt_width(MULT_CYC, DIV_CYC);

    flush_state_t r_state;
    flush_state_t w_state_nxt;

    logic       w_rs_e;
    logic       w_rt_e;
    logic       w_rs_m;
    logic       w_rt_m;
    logic       w_ld_stall;
    logic       w_br_stall;
    logic       w_md_stall;
    logic       w_stall;
    logic       w_trigger;
    logic       w_flush;
    logic [1:0] w_pc_sel;
    logic       w_md_busy;
    logic       w_md_start_ok;

    // Register 0 is never a real producer, so a zero write address never matches.
    assign w_rs_e = (hz.e_wa != '0) && (hz.d_rs == hz.e_wa);
    assign w_rt_e = (hz.e_wa != '0) && (hz.d_rt == hz.e_wa);
    assign w_rs_m = (hz.m_wa != '0) && (hz.d_rs == hz.m_wa);
    assign w_rt_m = (hz.m_wa != '0) && (hz.d_rt == hz.m_wa);

    assign w_ld_stall = hz.e_is_load &&
                        ((w_rs_e && (hz.d_rs_use || hz.d_branch)) ||
                         (w_rt_e && (hz.d_rt_use || hz.d_branch)));
    assign w_br_stall = hz.d_branch &&
                        ((w_rs_e || w_rt_e) || (hz.m_is_load && (w_rs_m || w_rt_m)));
    assign w_md_stall = hz.d_md_use && (w_md_busy || hz.e_md_start);
    assign w_stall    = w_ld_stall || w_br_stall || w_md_stall;

    assign w_trigger  = hz.m_exc || hz.m_eret || (hz.int_req && hz.m_valid);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_flush     = 1'b0;
        w_pc_sel    = PC_SEL_NORM;
        case (r_state)
            ST_RUN: begin
                if (w_trigger) begin
                    w_flush     = 1'b1;
                    w_pc_sel    = (hz.m_eret && !hz.m_exc) ? PC_SEL_EPC : PC_SEL_EXC;
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // A flush cancels the E-stage mult/div, so it must not load the counter.
    assign w_md_start_ok = hz.e_md_start && !w_flush;

    md_busy_cnt #(
        .CNT_W    (CNT_W),
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_busy_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_md_start_ok),
        .i_div   (hz.e_md_div),
        .o_busy  (w_md_busy)
    );

    always_comb begin
        hz.f_en    = 1'b1;
        hz.d_en    = 1'b1;
        hz.m_en    = 1'b1;
        hz.w_en    = 1'b1;
        hz.e_reset = 1'b0;
        hz.d_flush = 1'b0;
        if (!w_flush) begin
            if (w_stall) begin
                hz.f_en    = 1'b0;
                hz.d_en    = 1'b0;
                hz.e_reset = 1'b1;
            end else begin
                hz.d_flush = hz.d_clear_req;
            end
        end
    end

    assign hz.flush   = w_flush;
    assign hz.pc_sel  = w_pc_sel;
    assign hz.md_busy = w_md_busy;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline control unit for the 5-stage MIPS core. Generates the per-stage enable, bubble and flush strobes consumed by the F/D/E/M/W pipeline registers. Detects load-use and branch-operand hazards, tracks the multi-cycle multiply/divide unit, and sequences exception/interrupt/eret flushes. Sits beside the datapath; all hazard outputs are combinational from current inputs plus internal state.

## Interface
- `REG_W`, 5: register-address width
- `MULT_CYC`, 5: E-stage busy cycles for mult/multu
- `DIV_CYC`, 10: busy cycles for div/divu
- `clk` in 1: sole clock
- `reset` in 1: asynchronous, active-low reset
- `d_rs`, `d_rt` in REG_W: D-stage source registers
- `d_rs_use`, `d_rt_use` in 1: D instruction reads rs/rt in E (ALU/store) or later
- `d_branch` in 1: D instruction is a branch/jr, reads rs/rt in D
- `d_md_use` in 1: D instruction is mult/div/mfhi/mflo/mthi/mtlo
- `d_clear_req` in 1: branch unit requests D bubble (likely-not-taken annul)
- `e_wa`, `m_wa` in REG_W: destination registers in E, M (0 = none)
- `e_is_load`, `m_is_load` in 1: E/M instruction is a load
- `e_md_start` in 1: E instruction is mult/div, starts this cycle
- `e_md_div` in 1: 1 = div, 0 = mult (valid with `e_md_start`)
- `m_exc` in 1: exception detected on M instruction
- `m_eret` in 1: eret in M
- `m_valid` in 1: M holds a real (non-bubble) instruction
- `int_req` in 1: level interrupt request
- `f_en`, `d_en`, `m_en`, `w_en` out 1: register enables
- `d_flush` out 1: D-register clear (honoured only when `d_en`)
- `e_reset` out 1: E-register bubble insert
- `flush` out 1: clear all pipeline registers
- `pc_sel` out 2: 0 = normal, 1 = handler vector, 2 = EPC
- `md_busy` out 1: mult/div in progress

## Operation
- Hazards ignore register 0.
- `ld_stall` = `e_is_load` and `e_wa`≠0 and ((`d_rs_use`|`d_branch`) and `d_rs`==`e_wa` or same for rt).
- `br_stall` = `d_branch` and ((`e_wa`≠0 and match) or (`m_is_load` and `m_wa`≠0 and match)).
- `md_stall` = `d_md_use` and (`md_busy` or `e_md_start`).
- `stall` = any of the three; during stall: `f_en`=`d_en`=0, `e_reset`=1, `m_en`=`w_en`=1, `d_flush`=0.
- `d_flush` = `d_clear_req` and not stall.
- Mult/div counter `md_cnt` (4 bits min, sized for max(MULT_CYC,DIV_CYC)): on accepted `e_md_start` load MULT_CYC or DIV_CYC; else decrement to 0. `md_busy` = `md_cnt`≠0.
- Start is accepted only if `flush` is not asserted the same cycle (younger instruction cancelled).
- Flush FSM, states RUN, DRAIN:
  - RUN: trigger = `m_exc` or `m_eret` or (`int_req` and `m_valid`). On trigger: `flush`=1; `pc_sel`=2 if `m_eret` and not `m_exc`, else 1; next DRAIN.
  - DRAIN: `flush`=0, `pc_sel`=0, no triggers accepted, hazards evaluated normally; next RUN.
- `flush` overrides stall: when asserted, `e_reset`=0, `d_flush`=0, all enables 1.
- In-flight mult/div started before the trigger runs to completion; no abort.

## Timing
- Reset values: `md_cnt`=0, state RUN; hence `md_busy`=0, `flush`=0, `pc_sel`=0, all enables 1, `e_reset`=0, `d_flush`=0.
- Stall/flush outputs zero-latency (combinational), act on the next `clk` edge.
- `e_md_start` at edge t → `md_busy` high for exactly N cycles starting after t.
- Trigger in DRAIN is held off one cycle; level `int_req` re-evaluated in RUN.
- Reset mid-operation clears counter and FSM immediately.

## Structure
- Shared package: `PC_SEL_NORM/EXC/EPC` codes, FSM state encoding, default cycle counts.
- One sub-module natural: `md_busy_cnt` (load/decrement counter with busy output).

## Test plan
- `e_is_load`, `e_wa`=8, `d_rs`=8, `d_rs_use` → one cycle `f_en`=`d_en`=0, `e_reset`=1; next cycle clear.
- `e_wa`=0, `d_rs`=0, load → no stall.
- `e_md_start`, `e_md_div`=1, then `d_md_use` held → `md_busy` 10 cycles, stall for all 11 including start cycle.
- `m_exc` and `e_md_start` same cycle → `flush`=1, `pc_sel`=1, `md_busy` stays 0, next cycle DRAIN ignores `int_req`.
- `m_eret` with `ld_stall` active → `flush`=1, `pc_sel`=2, `e_reset`=0, enables 1.
- `d_clear_req` during `br_stall` → `d_flush`=0; after stall clears → `d_flush`=1 with `d_en`=1.
